// File: rtl/mem_retry_buffer.sv
// Tracks outstanding memory requests by tag, transparently replays nacked requests,
// forwards load acks to the core and swallows store acks; protocol violations set a sticky error.
module mem_retry_buffer #(
  parameter int ADDR_BITS   = 26,
  parameter int DATA_BITS   = 128,
  parameter int TAG_BITS    = 5,
  parameter int DEPTH       = 4,
  parameter int MAX_RETRIES = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       core_req_val,
  output logic                       core_req_rdy,
  input  logic                       core_req_rw,
  input  logic [ADDR_BITS-1:0]       core_req_addr,
  input  logic [TAG_BITS-1:0]        core_req_tag,
  input  logic [DATA_BITS-1:0]       core_req_data,
  output logic                       core_resp_val,
  output logic [TAG_BITS-1:0]        core_resp_tag,
  output logic [DATA_BITS-1:0]       core_resp_data,
  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic                       mem_req_rw,
  output logic [ADDR_BITS-1:0]       mem_req_addr,
  output logic [TAG_BITS-1:0]        mem_req_tag,
  output logic [DATA_BITS-1:0]       mem_req_data,
  input  logic                       mem_resp_val,
  input  logic                       mem_resp_nack,
  input  logic [TAG_BITS-1:0]        mem_resp_tag,
  input  logic [DATA_BITS-1:0]       mem_resp_data,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       error
);

  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RET_BITS = $clog2(MAX_RETRIES + 1);
  localparam logic [RET_BITS-1:0] RET_MAX = RET_BITS'(MAX_RETRIES);

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_replay;
  logic [DEPTH-1:0]     r_rw;
  logic [ADDR_BITS-1:0] r_addr    [DEPTH];
  logic [TAG_BITS-1:0]  r_tag     [DEPTH];
  logic [DATA_BITS-1:0] r_data    [DEPTH];
  logic [RET_BITS-1:0]  r_retries [DEPTH];

  logic                 r_resp_val;
  logic [TAG_BITS-1:0]  r_resp_tag;
  logic [DATA_BITS-1:0] r_resp_data;
  logic [CNT_BITS-1:0]  r_outstanding;
  logic                 r_error;

  logic                 w_free_any;
  logic [IDX_BITS-1:0]  w_free_idx;
  logic                 w_replay_any;
  logic [IDX_BITS-1:0]  w_replay_idx;
  logic                 w_match_any;
  logic [IDX_BITS-1:0]  w_match_idx;
  logic                 w_conflict;
  logic                 w_accept;
  logic                 w_replay_fire;
  logic                 w_resp_ack;
  logic [DEPTH-1:0]     w_valid_nxt;
  logic [CNT_BITS-1:0]  w_cnt_nxt;

  // Descending scan so the lowest matching index wins for every search.
  always_comb begin
    w_free_any   = 1'b0;
    w_free_idx   = '0;
    w_replay_any = 1'b0;
    w_replay_idx = '0;
    w_match_any  = 1'b0;
    w_match_idx  = '0;
    w_conflict   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_BITS'(i);
      end
      if (r_valid[i] && r_replay[i]) begin
        w_replay_any = 1'b1;
        w_replay_idx = IDX_BITS'(i);
      end
      if (r_valid[i] && !r_replay[i] && (r_tag[i] == mem_resp_tag)) begin
        w_match_any = 1'b1;
        w_match_idx = IDX_BITS'(i);
      end
      if (r_valid[i] && (r_tag[i] == core_req_tag)) begin
        w_conflict = 1'b1;
      end
    end
  end

  always_comb begin
    if (w_replay_any) begin
      mem_req_val  = reset;
      mem_req_rw   = r_rw[w_replay_idx];
      mem_req_addr = r_addr[w_replay_idx];
      mem_req_tag  = r_tag[w_replay_idx];
      mem_req_data = r_data[w_replay_idx];
      core_req_rdy = 1'b0;
    end else begin
      mem_req_val  = reset & core_req_val & w_free_any;
      mem_req_rw   = core_req_rw;
      mem_req_addr = core_req_addr;
      mem_req_tag  = core_req_tag;
      mem_req_data = core_req_data;
      core_req_rdy = reset & mem_req_rdy & w_free_any;
    end
  end

  assign w_accept      = core_req_val & core_req_rdy;
  assign w_replay_fire = w_replay_any & mem_req_val & mem_req_rdy;
  assign w_resp_ack    = mem_resp_val & w_match_any & ~mem_resp_nack;

  // Next-state occupancy feeds the registered count so it always equals popcount(r_valid).
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_accept) begin
      w_valid_nxt[w_free_idx] = 1'b1;
    end
    if (w_resp_ack) begin
      w_valid_nxt[w_match_idx] = 1'b0;
    end
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_BITS'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid       <= '0;
      r_replay      <= '0;
      r_resp_val    <= 1'b0;
      r_resp_tag    <= '0;
      r_resp_data   <= '0;
      r_outstanding <= '0;
      r_error       <= 1'b0;
    end else begin
      r_valid       <= w_valid_nxt;
      r_outstanding <= w_cnt_nxt;
      r_resp_val    <= 1'b0;
      if (w_accept) begin
        r_replay[w_free_idx]  <= 1'b0;
        r_rw[w_free_idx]      <= core_req_rw;
        r_addr[w_free_idx]    <= core_req_addr;
        r_tag[w_free_idx]     <= core_req_tag;
        r_data[w_free_idx]    <= core_req_data;
        r_retries[w_free_idx] <= '0;
        if (w_conflict) begin
          r_error <= 1'b1;
        end
      end
      if (w_replay_fire) begin
        r_replay[w_replay_idx] <= 1'b0;
      end
      if (mem_resp_val) begin
        if (!w_match_any) begin
          r_error <= 1'b1;
        end else if (mem_resp_nack) begin
          r_replay[w_match_idx] <= 1'b1;
          if (r_retries[w_match_idx] == RET_MAX) begin
            r_error <= 1'b1;
          end else begin
            r_retries[w_match_idx] <= r_retries[w_match_idx] + 1'b1;
          end
        end else if (!r_rw[w_match_idx]) begin
          r_resp_val  <= 1'b1;
          r_resp_tag  <= mem_resp_tag;
          r_resp_data <= mem_resp_data;
        end
      end
    end
  end

  assign core_resp_val  = r_resp_val;
  assign core_resp_tag  = r_resp_tag;
  assign core_resp_data = r_resp_data;
  assign outstanding    = r_outstanding;
  assign error          = r_error;

endmodule

// File: tb/tb_mem_retry_buffer.sv
// Directed bench for mem_retry_buffer: one table of cycle vectors plus hand-built
// sequences for full buffer, retry exhaustion, unknown tags and mid-operation reset.
module tb_mem_retry_buffer;

  localparam int AB = 26;
  localparam int DB = 128;
  localparam int TW = 5;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req_val, core_req_rdy, core_req_rw;
  logic [AB-1:0] core_req_addr;
  logic [TW-1:0] core_req_tag;
  logic [DB-1:0] core_req_data;
  logic          core_resp_val;
  logic [TW-1:0] core_resp_tag;
  logic [DB-1:0] core_resp_data;
  logic          mem_req_val, mem_req_rdy, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic [DB-1:0] mem_req_data;
  logic          mem_resp_val, mem_resp_nack;
  logic [TW-1:0] mem_resp_tag;
  logic [DB-1:0] mem_resp_data;
  logic [CB-1:0] outstanding;
  logic          error;

  always #5 clk = ~clk;

  mem_retry_buffer #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TW), .DEPTH(4), .MAX_RETRIES(15)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_val(core_req_val), .core_req_rdy(core_req_rdy), .core_req_rw(core_req_rw),
    .core_req_addr(core_req_addr), .core_req_tag(core_req_tag), .core_req_data(core_req_data),
    .core_resp_val(core_resp_val), .core_resp_tag(core_resp_tag), .core_resp_data(core_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack), .mem_resp_tag(mem_resp_tag),
    .mem_resp_data(mem_resp_data), .outstanding(outstanding), .error(error)
  );

  typedef struct {
    logic          rst, cval, crw;
    logic [AB-1:0] caddr;
    logic [TW-1:0] ctag;
    logic [DB-1:0] cdata;
    logic          mrdy, rval, rnack;
    logic [TW-1:0] rtag;
    logic [DB-1:0] rdata;
    logic          eRdy, eMval;
    logic [TW-1:0] eMtag;
    logic [AB-1:0] eMaddr;
    logic [DB-1:0] eMdata;
    logic          eRval;
    logic [TW-1:0] eRtag;
    logic [DB-1:0] eRdata;
    logic [CB-1:0] eOut;
    logic          eErr;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   bad    = 0;
  int   curVec = 0;

  function automatic vec_t mk(
    int rst, int cval, int crw, int caddr, int ctag, longint unsigned cdata,
    int mrdy, int rval, int rnack, int rtag, longint unsigned rdata,
    int eRdy, int eMval, int eMtag, int eMaddr, longint unsigned eMdata,
    int eRval, int eRtag, longint unsigned eRdata, int eOut, int eErr);
    vec_t v;
    v.rst = 1'(rst);     v.cval = 1'(cval);   v.crw = 1'(crw);
    v.caddr = AB'(caddr); v.ctag = TW'(ctag); v.cdata = DB'(cdata);
    v.mrdy = 1'(mrdy);   v.rval = 1'(rval);   v.rnack = 1'(rnack);
    v.rtag = TW'(rtag);  v.rdata = DB'(rdata);
    v.eRdy = 1'(eRdy);   v.eMval = 1'(eMval); v.eMtag = TW'(eMtag);
    v.eMaddr = AB'(eMaddr); v.eMdata = DB'(eMdata);
    v.eRval = 1'(eRval); v.eRtag = TW'(eRtag); v.eRdata = DB'(eRdata);
    v.eOut = CB'(eOut);  v.eErr = 1'(eErr);
    return v;
  endfunction

  task automatic checkField(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (vector %0d): got %0h expected %0h", name, curVec, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    core_req_val  = v.cval;
    core_req_rw   = v.crw;
    core_req_addr = v.caddr;
    core_req_tag  = v.ctag;
    core_req_data = v.cdata;
    mem_req_rdy   = v.mrdy;
    mem_resp_val  = v.rval;
    mem_resp_nack = v.rnack;
    mem_resp_tag  = v.rtag;
    mem_resp_data = v.rdata;
  endtask

  // Phase 0 checks combinational outputs before the edge, phase 1 registered outputs after it.
  task automatic checkOutput(input vec_t v, input bit phase);
    if (!phase) begin
      checkField("core_req_rdy", DB'(core_req_rdy), DB'(v.eRdy));
      checkField("mem_req_val", DB'(mem_req_val), DB'(v.eMval));
      if (v.eMval) begin
        checkField("mem_req_tag", DB'(mem_req_tag), DB'(v.eMtag));
        checkField("mem_req_addr", DB'(mem_req_addr), DB'(v.eMaddr));
        checkField("mem_req_data", mem_req_data, v.eMdata);
      end
    end else begin
      checkField("core_resp_val", DB'(core_resp_val), DB'(v.eRval));
      if (v.eRval) begin
        checkField("core_resp_tag", DB'(core_resp_tag), DB'(v.eRtag));
        checkField("core_resp_data", core_resp_data, v.eRdata);
      end
      checkField("outstanding", DB'(outstanding), DB'(v.eOut));
      checkField("error", DB'(error), DB'(v.eErr));
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v, 1'b0);
    @(posedge clk);
    #1;
    checkOutput(v, 1'b1);
    curVec++;
  endtask

  initial begin
    reset = 1'b0; core_req_val = 1'b0; core_req_rw = 1'b0; core_req_addr = '0;
    core_req_tag = '0; core_req_data = '0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
    mem_resp_nack = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
    @(posedge clk);
    #1;

    // rst cval rw addr tag data | mrdy rval nack rtag rdata | eRdy eMval eMtag eMaddr eMdata | eRval eRtag eRdata eOut eErr
    vecs.push_back(mk(0,1,0,'h40,3,0,         1,0,0,0,0,           0,0,0,0,0,            0,0,0,0,0));
    vecs.push_back(mk(1,1,0,'h40,3,0,         1,0,0,0,0,           1,1,3,'h40,0,         0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,0,0,0,0,           1,0,0,0,0,            0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,1,0,3,'hDEADBEEF,  1,0,0,0,0,            1,3,'hDEADBEEF,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,0,0,0,0,           1,0,0,0,0,            0,0,0,0,0));
    vecs.push_back(mk(1,1,1,'h80,7,'h1234,    1,0,0,0,0,           1,1,7,'h80,'h1234,    0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,1,0,7,'hFFFF,      1,0,0,0,0,            0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,0,0,0,0,           1,0,0,0,0,            0,0,0,0,0));
    vecs.push_back(mk(1,1,0,'h100,2,'h55,     1,0,0,0,0,           1,1,2,'h100,'h55,     0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,1,1,2,0,           1,0,0,0,0,            0,0,0,1,0));
    vecs.push_back(mk(1,1,0,'h999,10,'h77,    0,0,0,0,0,           0,1,2,'h100,'h55,     0,0,0,1,0));
    vecs.push_back(mk(1,1,0,'h999,10,'h77,    1,0,0,0,0,           0,1,2,'h100,'h55,     0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,1,1,2,0,           1,0,0,0,0,            0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,0,0,0,0,           0,1,2,'h100,'h55,     0,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,1,0,2,'hCAFE,      1,0,0,0,0,            1,2,'hCAFE,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,            1,0,0,0,0,           1,0,0,0,0,            0,0,0,0,0));
    vecs.push_back(mk(1,1,0,'h200,5,0,        1,0,0,0,0,           1,1,5,'h200,0,        0,0,0,1,0));
    vecs.push_back(mk(1,1,0,'h204,5,'h9,      1,0,0,0,0,           1,1,5,'h204,'h9,      0,0,0,2,1));
    vecs.push_back(mk(1,0,0,0,0,0,            1,0,0,0,0,           1,0,0,0,0,            0,0,0,2,1));
    vecs.push_back(mk(0,0,0,0,0,0,            1,0,0,0,0,           0,0,0,0,0,            0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i]);
    end

    // Full buffer; the freed slot 1 is proven by replay priority over slot 3.
    for (int t = 0; t < 4; t++) begin
      runVec(mk(1,1,0,'h10*(t+1),t,0,     1,0,0,0,0,           1,1,t,'h10*(t+1),0,   0,0,0,t+1,0));
    end
    runVec(mk(1,1,0,'h500,8,'h8,          1,1,0,1,'hAA11,      0,0,0,0,0,            1,1,'hAA11,3,0));
    runVec(mk(1,1,0,'h500,8,'h8,          1,0,0,0,0,           1,1,8,'h500,'h8,      0,0,0,4,0));
    runVec(mk(1,0,0,0,0,0,                0,1,1,3,0,           0,0,0,0,0,            0,0,0,4,0));
    runVec(mk(1,0,0,0,0,0,                0,1,1,8,0,           0,1,3,'h40,0,         0,0,0,4,0));
    runVec(mk(1,0,0,0,0,0,                1,0,0,0,0,           0,1,8,'h500,'h8,      0,0,0,4,0));
    runVec(mk(1,0,0,0,0,0,                1,0,0,0,0,           0,1,3,'h40,0,         0,0,0,4,0));
    runVec(mk(0,0,0,0,0,0,                1,0,0,0,0,           0,0,0,0,0,            0,0,0,0,0));

    // Ack for a tag nothing is waiting on.
    runVec(mk(1,0,0,0,0,0,                1,1,0,9,'h1,         1,0,0,0,0,            0,0,0,0,1));
    runVec(mk(0,0,0,0,0,0,                1,0,0,0,0,           0,0,0,0,0,            0,0,0,0,0));

    // Retry exhaustion: the 16th nack flags error but the replay is still issued.
    runVec(mk(1,1,0,'h300,4,'h3,          1,0,0,0,0,           1,1,4,'h300,'h3,      0,0,0,1,0));
    for (int k = 1; k <= 16; k++) begin
      runVec(mk(1,0,0,0,0,0,              1,1,1,4,0,           1,0,0,0,0,            0,0,0,1,(k == 16) ? 1 : 0));
      runVec(mk(1,0,0,0,0,0,              1,0,0,0,0,           0,1,4,'h300,'h3,      0,0,0,1,(k == 16) ? 1 : 0));
    end
    runVec(mk(1,0,0,0,0,0,                1,1,0,4,'hF00D,      1,0,0,0,0,            1,4,'hF00D,0,1));
    runVec(mk(0,0,0,0,0,0,                1,0,0,0,0,           0,0,0,0,0,            0,0,0,0,0));

    // Reset mid-operation, including a same-cycle accept and ack beforehand.
    runVec(mk(1,1,0,'hA0,10,0,            1,0,0,0,0,           1,1,10,'hA0,0,        0,0,0,1,0));
    runVec(mk(1,1,0,'hB0,11,0,            1,0,0,0,0,           1,1,11,'hB0,0,        0,0,0,2,0));
    runVec(mk(1,1,0,'hC0,12,0,            1,0,0,0,0,           1,1,12,'hC0,0,        0,0,0,3,0));
    runVec(mk(1,1,0,'hD0,13,0,            1,1,0,10,'h1010,     1,1,13,'hD0,0,        1,10,'h1010,3,0));
    runVec(mk(0,0,0,0,0,0,                1,0,0,0,0,           0,0,0,0,0,            0,0,0,0,0));
    runVec(mk(1,0,0,0,0,0,                1,1,0,11,'h2,        1,0,0,0,0,            0,0,0,0,1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
